jtag_host_shifter: RTL and testbench

JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

---
 rtl/jtag_host_shifter.sv | 184 ++++++++++++++++++
 tb/tb_jtag_host_shifter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_shifter.sv
`default_nettype none
// ============================================================================
// jtag_host_shifter : command-driven JTAG host issuing TLR, IR and DR scans
// Revision 1.0
// ============================================================================
module jtag_host_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_len_i,
  input  logic [31:0] cmd_tdi_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  output logic        busy_o,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  input  logic        jtag_tdo_i
);

  localparam logic [8:0] C_RISE  = 9'(CLK_DIV - 1);
  localparam logic [8:0] C_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [1:0] C_OP_DR = 2'd0;
  localparam logic [1:0] C_OP_IR = 2'd1;

  typedef enum logic [2:0] {AUTO_TLR, IDLE, PRE, SHIFT, POST, RESP} state_t;

  state_t      state_q, state_d;
  logic [8:0]  div_q, div_d;
  logic [2:0]  step_q, step_d;
  logic [4:0]  bit_q, bit_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [31:0] tdo_q, tdo_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;

  logic [2:0]  pre_last;
  logic [7:0]  pre_tms;
  logic [2:0]  step_nx;
  logic [4:0]  bit_nx;

  // PRE walks Run-Test/Idle to Shift-DR / Shift-IR, or all the way to Test-Logic-Reset
  always_comb begin
    case (op_q)
      C_OP_DR: begin pre_last = 3'd2; pre_tms = 8'b0000_0001; end
      C_OP_IR: begin pre_last = 3'd3; pre_tms = 8'b0000_0011; end
      default: begin pre_last = 3'd5; pre_tms = 8'b0001_1111; end
    endcase
  end

  assign step_nx = step_q + 3'd1;
  assign bit_nx  = bit_q + 5'd1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = step_q;
    bit_d   = bit_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    tdo_d   = tdo_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          len_d   = cmd_len_i;
          data_d  = cmd_tdi_i;
          tdo_d   = '0;
          state_d = PRE;
          div_d   = '0;
          step_d  = '0;
          tms_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: begin
        div_d = div_q + 9'd1;
        if (div_q == C_RISE) begin
          tck_d = 1'b1;
          if (state_q == SHIFT) tdo_d[bit_q] = jtag_tdo_i;
        end else if (div_q == C_LAST) begin
          // TCK falls and the next TCK cycle's TMS/TDI are launched together
          tck_d = 1'b0;
          div_d = '0;
          tms_d = 1'b0;
          tdi_d = 1'b0;
          case (state_q)
            AUTO_TLR: begin
              if (step_q == 3'd5) begin
                state_d = IDLE;
              end else begin
                step_d = step_nx;
                tms_d  = (step_nx != 3'd5);
              end
            end
            PRE: begin
              if (step_q == pre_last) begin
                if (op_q == C_OP_DR || op_q == C_OP_IR) begin
                  state_d = SHIFT;
                  bit_d   = '0;
                  tms_d   = (len_q == 5'd0);
                  tdi_d   = data_q[0];
                end else begin
                  state_d = RESP;
                end
              end else begin
                step_d = step_nx;
                tms_d  = pre_tms[step_nx];
              end
            end
            SHIFT: begin
              if (bit_q == len_q) begin
                state_d = POST;
                step_d  = '0;
                tms_d   = 1'b1;
              end else begin
                bit_d = bit_nx;
                tms_d = (bit_nx == len_q);
                tdi_d = data_q[bit_nx];
              end
            end
            POST: begin
              if (step_q == 3'd1) state_d = RESP;
              else                step_d  = 3'd1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= AUTO_TLR;
      div_q   <= '0;
      step_q  <= '0;
      bit_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      data_q  <= '0;
      tdo_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      tdo_q   <= tdo_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_tdo_o   = tdo_q;
  assign jtag_tck_o  = tck_q;
  assign jtag_tms_o  = tms_q;
  assign jtag_tdi_o  = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_host_shifter.sv
`default_nettype none
// Directed bench for jtag_host_shifter with a behavioural TAP (IDCODE 0x249511C3, IR length 5).
module tb_jtag_host_shifter;

  localparam int          CLK_DIV    = 2;
  localparam logic [31:0] IDCODE     = 32'h2495_11C3;
  localparam logic [4:0]  IR_IDCODE  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_tdi = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_tdo;
  logic        busy;
  logic        tck, tms, tdi, tdo;

  int          n_total = 0;
  int          n_pass  = 0;
  int          stray   = 0;
  int          tck_cnt = 0;
  logic [63:0] tms_log = 64'h0;
  logic [63:0] tdi_log = 64'h0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  jtag_host_shifter #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_len_i   (cmd_len),
    .cmd_tdi_i   (cmd_tdi),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_tdo_o   (rsp_tdo),
    .busy_o      (busy),
    .jtag_tck_o  (tck),
    .jtag_tms_o  (tms),
    .jtag_tdi_o  (tdi),
    .jtag_tdo_i  (tdo)
  );

  // Behavioural TAP controller
  localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
                         SH_DR = 4'd4, EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7,
                         UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                         EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

  logic [3:0]  tap_st  = TLR;
  logic [4:0]  ir      = IR_IDCODE;
  logic [4:0]  ir_sh   = 5'h0;
  logic [31:0] dr_sh   = 32'h0;
  logic        tap_tdo = 1'b0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR:     ir    <= IR_IDCODE;
      CAP_DR:  dr_sh <= (ir == IR_IDCODE) ? IDCODE : 32'h0;
      SH_DR:   dr_sh <= {tdi, dr_sh[31:1]};
      CAP_IR:  ir_sh <= 5'b00001;
      SH_IR:   ir_sh <= {tdi, ir_sh[4:1]};
      UPD_IR:  ir    <= ir_sh;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tap_tdo <= (tap_st == SH_DR) ? dr_sh[0] : (tap_st == SH_IR) ? ir_sh[0] : 1'b0;

  assign tdo = tap_tdo;

  // Pin log: TMS/TDI as seen by the TAP on each rising TCK
  always @(posedge tck) begin
    if (tck_cnt < 64) begin
      tms_log[tck_cnt[5:0]] = tms;
      tdi_log[tck_cnt[5:0]] = tdi;
    end
    tck_cnt = tck_cnt + 1;
  end

  always @(negedge clk)
    if (!rst && rsp_valid && exp_q.size() == 0) stray = stray + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_tms(input logic [1:0] op, input int n);
    logic [63:0] v;
    logic [5:0]  a, b;
    if (op > 2'd1) return 64'h1F;
    v = (op == 2'd0) ? 64'h1 : 64'h3;
    a = (op == 2'd0) ? 6'(3 + n - 1) : 6'(4 + n - 1);
    b = a + 6'd1;
    v[a] = 1'b1;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic clear_log();
    tck_cnt = 0;
    tms_log = 64'h0;
    tdi_log = 64'h0;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  task automatic release_reset(input string tag);
    int n;
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_lat"}, 64'(n), 64'(6 * 2 * CLK_DIV));
    check({tag, "_tcks"}, 64'(tck_cnt), 64'(6));
    check({tag, "_tms"}, tms_log, 64'h1F);
    check({tag, "_tdi"}, tdi_log, 64'h0);
    check({tag, "_no_rsp"}, 64'(stray), 64'(0));
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, input bit hold);
    int          n, tcks, lat, w, cnt_at;
    logic [31:0] mask, exp_rsp, held;
    logic [63:0] exp_tdi;
    bit          ok;
    n    = int'(len) + 1;
    mask = (len == 5'd31) ? 32'hFFFF_FFFF : 32'((64'h1 << n) - 64'h1);
    case (op)
      2'd0:    begin exp_rsp = IDCODE & mask; tcks = n + 5; exp_tdi = 64'(data & mask) << 3; end
      2'd1:    begin exp_rsp = 32'h1 & mask;  tcks = n + 6; exp_tdi = 64'(data & mask) << 4; end
      default: begin exp_rsp = 32'h0;         tcks = 6;     exp_tdi = 64'h0; end
    endcase
    @(negedge clk);
    clear_log();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_tdi   = data;
    rsp_ready = !hold;
    exp_q.push_back(exp_rsp);
    wait_ready(tag, w);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = 5'd0;
    cmd_tdi   = 32'hDEAD_BEEF;
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(tcks * 2 * CLK_DIV));
    check({tag, "_tcks"}, 64'(tck_cnt), 64'(tcks));
    check({tag, "_tms"}, tms_log, exp_tms(op, n));
    check({tag, "_tdi"}, tdi_log, exp_tdi);
    check({tag, "_tck_low"}, 64'(tck), 64'(0));
    if (hold) begin
      held   = rsp_tdo;
      cnt_at = tck_cnt;
      ok     = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (!(rsp_valid && rsp_tdo === held && !cmd_ready && !tck && !tms && !tdi)) ok = 1'b0;
      end
      check({tag, "_hold_stable"}, 64'(ok), 64'(1));
      check({tag, "_hold_no_tck"}, 64'(tck_cnt), 64'(cnt_at));
      rsp_ready = 1'b1;
    end
    check({tag, "_rsp"}, 64'(rsp_tdo), 64'(exp_q[0]));
    @(posedge clk);
    void'(exp_q.pop_front());
    @(negedge clk);
    check({tag, "_rsp_done"}, 64'(rsp_valid), 64'(0));
    check({tag, "_ready_again"}, 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int w;
    repeat (2) @(negedge clk);
    check("rst_tck",   64'(tck),       64'(0));
    check("rst_tms",   64'(tms),       64'(1));
    check("rst_tdi",   64'(tdi),       64'(0));
    check("rst_ready", 64'(cmd_ready), 64'(0));
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_tdo",   64'(rsp_tdo),   64'(0));
    check("rst_busy",  64'(busy),      64'(1));

    release_reset("auto_tlr");

    run_cmd("ir_idcode", 2'd1, 5'd4,  32'h0000_0001, 1'b0);
    run_cmd("dr_idcode", 2'd0, 5'd31, 32'h0000_0000, 1'b0);
    run_cmd("dr_len1",   2'd0, 5'd0,  32'h0000_0001, 1'b0);
    run_cmd("dr_len8",   2'd0, 5'd7,  32'h0000_00A5, 1'b0);
    run_cmd("tlr_op2",   2'd2, 5'd9,  32'hFFFF_FFFF, 1'b0);
    run_cmd("tlr_op3",   2'd3, 5'd17, 32'h1234_5678, 1'b0);
    run_cmd("dr_hold",   2'd0, 5'd3,  32'h0000_000F, 1'b1);

    // Abort a 32-bit DR scan while bit 10 is on the wire
    @(negedge clk);
    clear_log();
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_len   = 5'd31;
    cmd_tdi   = 32'hFFFF_0000;
    exp_q.push_back(IDCODE);
    wait_ready("abort", w);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (tck_cnt < 14 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("abort_reach_bit10", 64'(tck_cnt), 64'(14));
    #1 rst = 1'b1;
    #1;
    check("abort_tck",   64'(tck),       64'(0));
    check("abort_tms",   64'(tms),       64'(1));
    check("abort_valid", 64'(rsp_valid), 64'(0));
    check("abort_ready", 64'(cmd_ready), 64'(0));
    check("abort_busy",  64'(busy),      64'(1));
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_reset("abort_tlr");

    run_cmd("dr_after_abort", 2'd0, 5'd15, 32'h0000_5A5A, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("no_stray_rsp",     64'(stray),        64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
